// File: rtl/sdmac_pkg.sv
// rtl/sdmac_pkg.sv - shared state encoding and constants for the SCSI DMA transfer controller
package sdmac_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_REQ     = 3'd1;
   localparam logic [2:0] ST_OWN     = 3'd2;
   localparam logic [2:0] ST_CYCLE   = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   localparam int          SDMAC_BURST_LEN = 4;
   localparam logic [31:0] ADDR_INC        = 32'd4;

   // SCSI->memory needs a longword in the FIFO, memory->SCSI needs room for one.
   function automatic logic data_ready(input logic dir, input logic empty, input logic full);
      return dir ? !full : !empty;
   endfunction

endpackage

// File: rtl/dma_addr_cntr.sv
// rtl/dma_addr_cntr.sv - transfer address counter: load, longword increment, natural 32-bit wrap
module dma_addr_cntr
   import sdmac_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET_,
   input  logic        LD,
   input  logic [31:0] D,
   input  logic        INC,
   output logic [31:0] Q
);

   always_ff @(negedge CLK or negedge RESET_) begin
      if (!RESET_)
         Q <= '0;
      else if (LD)
         Q <= D;
      else if (INC)
         Q <= Q + ADDR_INC;
   end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// rtl/dma_xfer_ctrl.sv - bus-master sequencer moving longwords between the SCSI FIFO and memory
module dma_xfer_ctrl
   import sdmac_pkg::*;
#(
   parameter int BURST_LEN = SDMAC_BURST_LEN
)(
   input  logic        CLK,
   input  logic        RESET_,
   input  logic        DMAENA,
   input  logic        DMADIR,
   input  logic        ACR_LD,
   input  logic [31:0] ACR_D,
   input  logic        FIFO_EMPTY,
   input  logic        FIFO_FULL,
   output logic        FIFO_RD,
   output logic        FIFO_WR,
   output logic        BR_,
   output logic        BGACK_,
   input  logic        BG_,
   input  logic        DSACK_,
   input  logic        BERR_,
   output logic        AS_,
   output logic        RW,
   output logic [31:0] ADDR,
   output logic        DMA_ACTIVE,
   output logic        DMA_ERR
);

   localparam int            BW        = $clog2(BURST_LEN + 1);
   localparam logic [BW-1:0] BEATS_MAX = BW'(BURST_LEN);

   logic [2:0]    state;
   logic [BW-1:0] beats;
   logic          ready;
   logic          ack;
   logic          err;
   logic          addr_ld;

   assign ready   = data_ready(DMADIR, FIFO_EMPTY, FIFO_FULL);
   // A bus error wins over a simultaneous DSACK_.
   assign err     = (state == ST_CYCLE) && !AS_ && !BERR_;
   assign ack     = (state == ST_CYCLE) && !AS_ && !DSACK_ && BERR_;
   assign addr_ld = ACR_LD && (state == ST_IDLE);

   assign BR_        = (state != ST_REQ);
   assign BGACK_     = !((state == ST_OWN) || (state == ST_CYCLE));
   assign DMA_ACTIVE = (state == ST_OWN) || (state == ST_CYCLE) || (state == ST_RELEASE);

   dma_addr_cntr u_addr_cntr (
      .CLK    (CLK),
      .RESET_ (RESET_),
      .LD     (addr_ld),
      .D      (ACR_D),
      .INC    (ack),
      .Q      (ADDR)
   );

   always_ff @(negedge CLK or negedge RESET_) begin
      if (!RESET_) begin
         state   <= ST_IDLE;
         beats   <= '0;
         AS_     <= 1'b1;
         RW      <= 1'b1;
         FIFO_RD <= 1'b0;
         FIFO_WR <= 1'b0;
         DMA_ERR <= 1'b0;
      end else begin
         FIFO_RD <= ack && !DMADIR;
         FIFO_WR <= ack && DMADIR;
         case (state)
            ST_IDLE: begin
               if (ACR_LD)
                  DMA_ERR <= 1'b0;
               if (DMAENA && ready && !DMA_ERR)
                  state <= ST_REQ;
            end
            ST_REQ: begin
               if (!DMAENA)
                  state <= ST_IDLE;
               else if (!BG_)
                  state <= ST_OWN;
            end
            ST_OWN: begin
               state <= ST_CYCLE;
               AS_   <= 1'b0;
               RW    <= DMADIR;
            end
            ST_CYCLE: begin
               if (!AS_) begin
                  if (err) begin
                     AS_     <= 1'b1;
                     DMA_ERR <= 1'b1;
                     state   <= ST_RELEASE;
                  end else if (ack) begin
                     AS_   <= 1'b1;
                     beats <= beats + BW'(1);
                  end
               // AS_ high here is the gap after a beat, once the FIFO flags reflect the strobe.
               end else if ((beats < BEATS_MAX) && DMAENA && ready) begin
                  AS_ <= 1'b0;
                  RW  <= DMADIR;
               end else begin
                  state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               state <= ST_IDLE;
               beats <= '0;
               RW    <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// tb/tb_dma_xfer_ctrl.sv - directed and randomized bench for dma_xfer_ctrl with bus/FIFO responder
module tb_dma_xfer_ctrl;

   localparam int BL = 4;

   logic        CLK = 1'b0;
   logic        RESET_ = 1'b0;
   logic        DMAENA = 1'b0;
   logic        DMADIR = 1'b0;
   logic        ACR_LD = 1'b0;
   logic [31:0] ACR_D = '0;
   logic        FIFO_EMPTY = 1'b1;
   logic        FIFO_FULL = 1'b0;
   logic        FIFO_RD, FIFO_WR, BR_, BGACK_, AS_, RW, DMA_ACTIVE, DMA_ERR;
   logic        BG_ = 1'b1;
   logic        DSACK_ = 1'b1;
   logic        BERR_ = 1'b1;
   logic [31:0] ADDR;

   int n_checks = 0, n_pass = 0, n_fail = 0;

   int          fifo_lvl = 0, fifo_cap = 1000;
   int          rd_cnt = 0, wr_cnt = 0, tenure_beats = 0, br_cycles = 0;
   int          wait_max = 0, wait_cnt = 0, bg_dly = 0, berr_at = -1;
   bit          berr_dsack = 0, hold_dsack = 0, in_cycle = 0, cyc_berr = 0, addr_moved = 0;
   logic        prev_bgack = 1'b1;
   logic [31:0] cyc_addr = '0;
   logic [31:0] addr_log[$];
   logic        rw_log[$];
   int          tenures[$];

   dma_xfer_ctrl #(.BURST_LEN(BL)) dut (
      .CLK        (CLK),
      .RESET_     (RESET_),
      .DMAENA     (DMAENA),
      .DMADIR     (DMADIR),
      .ACR_LD     (ACR_LD),
      .ACR_D      (ACR_D),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_FULL  (FIFO_FULL),
      .FIFO_RD    (FIFO_RD),
      .FIFO_WR    (FIFO_WR),
      .BR_        (BR_),
      .BGACK_     (BGACK_),
      .BG_        (BG_),
      .DSACK_     (DSACK_),
      .BERR_      (BERR_),
      .AS_        (AS_),
      .RW         (RW),
      .ADDR       (ADDR),
      .DMA_ACTIVE (DMA_ACTIVE),
      .DMA_ERR    (DMA_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock of the environment: FIFO model, memory slave and arbiter, sampled on the rising edge.
   task automatic tick();
      @(posedge CLK);
      if (FIFO_RD === 1'b1) begin
         rd_cnt++;
         tenure_beats++;
         if (fifo_lvl > 0) fifo_lvl--;
      end
      if (FIFO_WR === 1'b1) begin
         wr_cnt++;
         tenure_beats++;
         fifo_lvl++;
      end
      if (BR_ === 1'b0) br_cycles++;
      if (BGACK_ === 1'b1 && prev_bgack === 1'b0) begin
         tenures.push_back(tenure_beats);
         tenure_beats = 0;
      end
      prev_bgack = BGACK_;
      if (AS_ === 1'b0) begin
         if (!in_cycle) begin
            in_cycle = 1;
            cyc_addr = ADDR;
            addr_log.push_back(ADDR);
            rw_log.push_back(RW);
            cyc_berr = ((addr_log.size() - 1) == berr_at);
            wait_cnt = $urandom_range(0, wait_max);
         end else if (ADDR !== cyc_addr) begin
            addr_moved = 1;
         end
         if (wait_cnt == 0 && !hold_dsack) begin
            if (cyc_berr) begin
               BERR_ = 1'b0;
               if (berr_dsack) DSACK_ = 1'b0;
            end else begin
               DSACK_ = 1'b0;
            end
         end else if (wait_cnt > 0) begin
            wait_cnt--;
         end
      end else begin
         in_cycle = 0;
         DSACK_   = 1'b1;
         BERR_    = 1'b1;
      end
      if (BR_ === 1'b0) begin
         if (bg_dly == 0) BG_ = 1'b0;
         else bg_dly--;
      end else begin
         BG_    = 1'b1;
         bg_dly = $urandom_range(0, 3);
      end
      FIFO_EMPTY = (fifo_lvl == 0);
      FIFO_FULL  = (fifo_lvl >= fifo_cap);
   endtask

   task automatic clear_log();
      rd_cnt = 0; wr_cnt = 0; tenure_beats = 0; br_cycles = 0; addr_moved = 0;
      addr_log.delete();
      rw_log.delete();
      tenures.delete();
   endtask

   task automatic setup(input logic dir, input logic [31:0] a, input int lvl, input int cap, input int wmax);
      clear_log();
      DMAENA     = 1'b0;
      DMADIR     = dir;
      fifo_lvl   = lvl;
      fifo_cap   = cap;
      wait_max   = wmax;
      FIFO_EMPTY = (fifo_lvl == 0);
      FIFO_FULL  = (fifo_lvl >= fifo_cap);
      ACR_D      = a;
      ACR_LD     = 1'b1;
      tick();
      ACR_LD     = 1'b0;
      DMAENA     = 1'b1;
   endtask

   task automatic run_until_done(input string tag, input int exp_beats);
      int budget = 3000;
      int settle = 0;
      while (budget > 0 && settle < 8) begin
         tick();
         budget--;
         if ((rd_cnt + wr_cnt) >= exp_beats && tenures.size() > 0 && DMA_ACTIVE === 1'b0 && BR_ === 1'b1)
            settle++;
         else
            settle = 0;
      end
      check({tag, " done"}, 32'(budget > 0), 32'd1);
   endtask

   // Reference: n longwords at start, start+4, ... in greedy BL-beat tenures.
   task automatic check_xfer(input string tag, input logic [31:0] start, input int n, input logic dir);
      int rem = n;
      int t = 0;
      int exp_t;
      check({tag, " cycles"}, 32'(addr_log.size()), 32'(n));
      check({tag, " strobes"}, 32'(dir ? wr_cnt : rd_cnt), 32'(n));
      check({tag, " wrong strobe"}, 32'(dir ? rd_cnt : wr_cnt), 32'd0);
      for (int i = 0; i < addr_log.size() && i < n; i++) begin
         check($sformatf("%s addr[%0d]", tag, i), addr_log[i], start + 32'(4 * i));
         check($sformatf("%s rw[%0d]", tag, i), 32'(rw_log[i]), 32'(dir));
      end
      check({tag, " final addr"}, ADDR, start + 32'(4 * n));
      while (rem > 0) begin
         exp_t = (rem > BL) ? BL : rem;
         check($sformatf("%s tenure[%0d]", tag, t), 32'((t < tenures.size()) ? tenures[t] : -1), 32'(exp_t));
         rem -= exp_t;
         t++;
      end
      check({tag, " tenures"}, 32'(tenures.size()), 32'(t));
      check({tag, " addr stable"}, 32'(addr_moved), 32'd0);
      check({tag, " err"}, 32'(DMA_ERR), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " BR_"}, 32'(BR_), 32'd1);
      check({tag, " BGACK_"}, 32'(BGACK_), 32'd1);
      check({tag, " AS_"}, 32'(AS_), 32'd1);
      check({tag, " RW"}, 32'(RW), 32'd1);
      check({tag, " FIFO_RD"}, 32'(FIFO_RD), 32'd0);
      check({tag, " FIFO_WR"}, 32'(FIFO_WR), 32'd0);
      check({tag, " ADDR"}, ADDR, 32'd0);
      check({tag, " DMA_ACTIVE"}, 32'(DMA_ACTIVE), 32'd0);
      check({tag, " DMA_ERR"}, 32'(DMA_ERR), 32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      int          rn, rl, rw_dir;

      tick();
      tick();
      check_reset_outputs("reset");
      RESET_ = 1'b1;
      tick();
      tick();

      setup(1'b0, 32'h0000_1000, 8, 1000, 2);
      run_until_done("two_tenures", 8);
      check_xfer("two_tenures", 32'h0000_1000, 8, 1'b0);
      DMAENA = 1'b0;

      setup(1'b1, 32'h0000_2000, 0, 2, 1);
      run_until_done("fifo_full", 2);
      check_xfer("fifo_full", 32'h0000_2000, 2, 1'b1);
      DMAENA = 1'b0;

      setup(1'b0, 32'hFFFF_FFF8, 4, 1000, 0);
      run_until_done("wrap", 4);
      check_xfer("wrap", 32'hFFFF_FFF8, 4, 1'b0);
      DMAENA = 1'b0;

      setup(1'b0, 32'h0000_4000, 8, 1000, 1);
      berr_at = 1;
      run_until_done("berr", 1);
      check("berr cycles", 32'(addr_log.size()), 32'd2);
      check("berr strobes", 32'(rd_cnt), 32'd1);
      check("berr addr", ADDR, 32'h0000_4004);
      check("berr flag", 32'(DMA_ERR), 32'd1);
      check("berr tenure", 32'((tenures.size() > 0) ? tenures[0] : -1), 32'd1);
      br_cycles = 0;
      for (int k = 0; k < 30; k++) tick();
      check("berr no restart", 32'(br_cycles), 32'd0);
      clear_log();
      berr_at = -1;
      ACR_D   = 32'h0000_5000;
      ACR_LD  = 1'b1;
      tick();
      ACR_LD  = 1'b0;
      check("berr cleared", 32'(DMA_ERR), 32'd0);
      run_until_done("berr_resume", 7);
      check_xfer("berr_resume", 32'h0000_5000, 7, 1'b0);
      DMAENA = 1'b0;

      setup(1'b0, 32'h0000_6000, 3, 1000, 0);
      berr_at    = 0;
      berr_dsack = 1;
      run_until_done("berr_dsack", 0);
      check("berr_dsack strobes", 32'(rd_cnt), 32'd0);
      check("berr_dsack addr", ADDR, 32'h0000_6000);
      check("berr_dsack flag", 32'(DMA_ERR), 32'd1);
      DMAENA     = 1'b0;
      berr_at    = -1;
      berr_dsack = 0;
      ACR_LD     = 1'b1;
      tick();
      ACR_LD     = 1'b0;

      setup(1'b0, 32'h0000_3000, 8, 1000, 0);
      hold_dsack = 1;
      for (int k = 0; k < 50 && AS_ !== 1'b0; k++) tick();
      check("ena_drop in cycle", 32'(AS_), 32'd0);
      DMAENA = 1'b0;
      ACR_D  = 32'hDEAD_0000;
      ACR_LD = 1'b1;
      tick();
      ACR_LD     = 1'b0;
      hold_dsack = 0;
      run_until_done("ena_drop", 1);
      check_xfer("ena_drop", 32'h0000_3000, 1, 1'b0);

      for (int it = 0; it < 6; it++) begin
         ra     = $urandom;
         ra     = ra & 32'hFFFF_FFFC;
         rn     = $urandom_range(1, 10);
         rw_dir = $urandom_range(0, 1);
         rl     = $urandom_range(0, 5);
         if (rw_dir == 0) setup(1'b0, ra, rn, 1000, $urandom_range(0, 3));
         else             setup(1'b1, ra, rl, rl + rn, $urandom_range(0, 3));
         run_until_done($sformatf("rand%0d", it), rn);
         check_xfer($sformatf("rand%0d", it), ra, rn, rw_dir[0]);
         DMAENA = 1'b0;
      end

      setup(1'b0, 32'h0000_7000, 4, 1000, 0);
      hold_dsack = 1;
      for (int k = 0; k < 50 && AS_ !== 1'b0; k++) tick();
      check("reset_mid in cycle", 32'(AS_), 32'd0);
      #3;
      RESET_ = 1'b0;
      #1;
      check_reset_outputs("reset_mid");
      DMAENA     = 1'b0;
      hold_dsack = 0;
      for (int k = 0; k < 4; k++) tick();
      check("reset_mid strobes", 32'(rd_cnt + wr_cnt), 32'd0);
      check_reset_outputs("reset_mid held");
      RESET_ = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dma_xfer_ctrl.md
DMA_XFER_CTRL -- requirements
Module: dma_xfer_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4: maximum longword beats per bus tenure.
REQ-002 SHALL have port CLK  input  1  sole clock; all registers update on its falling edge.
REQ-003 SHALL have port RESET_  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port DMAENA  input  1  DMA enabled, from the control register.
REQ-005 SHALL have port DMADIR  input  1  direction: 0 = SCSI->memory (bus write), 1 = memory->SCSI (bus read).
REQ-006 SHALL have port ACR_LD  input  1  load address counter, one-cycle pulse.
REQ-007 SHALL have port ACR_D  input  32  address load value.
REQ-008 SHALL have port FIFO_EMPTY, FIFO_FULL  input  1 each  SCSI data FIFO status.
REQ-009 SHALL have port FIFO_RD, FIFO_WR  output  1 each  one-cycle FIFO pop/push strobes.
REQ-010 SHALL have port BR_, BGACK_  output  1 each  bus request / grant acknowledge, active-low.
REQ-011 SHALL have port BG_, DSACK_, BERR_  input  1 each  bus grant, cycle acknowledge, bus error, active-low.
REQ-012 SHALL have port AS_  output  1  address strobe, active-low; RW output 1, 1 = read.
REQ-013 SHALL have port ADDR  output  32  current transfer address.
REQ-014 SHALL have port DMA_ACTIVE, DMA_ERR  output  1 each  bus owned / sticky bus-error flag.

Function
REQ-015 SHALL implement states IDLE, REQ, OWN, CYCLE, RELEASE.
REQ-016 SHALL leave IDLE for REQ when DMAENA=1 and data is ready: DMADIR=0 with FIFO_EMPTY=0, or DMADIR=1 with FIFO_FULL=0.
REQ-017 SHALL assert BR_=0 in REQ and move to OWN on the first edge with BG_=0.
REQ-018 In OWN, SHALL assert BGACK_=0 and release BR_; DMA_ACTIVE=1 from OWN through RELEASE.
REQ-019 SHALL enter CYCLE one cycle after OWN, drive AS_=0 and RW=DMADIR, and hold ADDR stable until DSACK_=0.
REQ-020 On DSACK_=0, SHALL do all of the following in the same cycle: pulse FIFO_WR (DMADIR=1) or FIFO_RD (DMADIR=0) for one cycle, add 4 to ADDR, increment the beat count, and deassert AS_.
REQ-021 After a beat, SHALL start the next CYCLE only while beats < BURST_LEN, DMAENA=1 and data is ready; otherwise it SHALL go to RELEASE.
REQ-022 RELEASE SHALL drive BGACK_=1 for one cycle, then return to IDLE and clear the beat count.
REQ-023 ADDR SHALL wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-024 ACR_LD SHALL load ADDR only in IDLE; it SHALL be ignored in any other state.
REQ-025 If DMAENA falls during CYCLE, SHALL complete the current beat and then RELEASE; if it falls in REQ, SHALL drop BR_ and return to IDLE.
REQ-026 BERR_=0 in CYCLE SHALL end the cycle with no FIFO strobe and no ADDR increment, set DMA_ERR, and go to RELEASE.
REQ-027 DSACK_ and BERR_ low together SHALL be treated as a bus error.
REQ-028 While DMA_ERR=1, SHALL not leave IDLE; ACR_LD clears DMA_ERR.

Reset
REQ-029 RESET_=0 SHALL immediately force the IDLE state and these values: BR_=1, BGACK_=1, AS_=1, RW=1, FIFO_RD=0, FIFO_WR=0, ADDR=0, beat count=0, DMA_ACTIVE=0, DMA_ERR=0.
REQ-030 A reset asserted mid-cycle SHALL abandon the bus cycle with no FIFO strobe.

Structure
REQ-031 The state encoding, BURST_LEN default and ADDR_INC=4 SHALL live in shared package sdmac_pkg.
REQ-032 The address counter (load, +4, wrap) SHALL be sub-module dma_addr_cntr.

Verification
REQ-033 Load ACR=0x00001000, DMADIR=0, FIFO holds 8 longwords, DMAENA=1, BG_ granted -> two tenures of 4 beats each, 8 FIFO_RD pulses, final ADDR=0x00001020.
REQ-034 DMADIR=1, FIFO_FULL set after 2 beats -> release after 2 FIFO_WR pulses, RW=1 throughout, ADDR advanced by 8.
REQ-035 BERR_=0 on beat 2 -> 1 strobe only, DMA_ERR=1, bus released, no restart until ACR_LD.
REQ-036 Load ACR=0xFFFFFFF8, run 4 beats -> ADDR sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-037 Drop DMAENA while AS_=0 -> beat completes, BGACK_ released next; ACR_LD pulsed in CYCLE is ignored.
REQ-038 Assert RESET_ while AS_=0 -> all outputs at reset values immediately, no FIFO strobe.
